// File: rtl/glogic_clk_seq_if.sv
// Control/status bundle between the clock/reset sequencer and its environment.
// The sequencer side uses the slave modport; the stimulus/consumer side uses master.
interface glogic_clk_seq_if;
    logic PLL_LOCK;   // asynchronous PLL lock flag
    logic PLL_REQ;    // level: request PLL as core clock source
    logic SLEEP_REQ;  // single-cycle sleep request pulse
    logic WAKE;       // asynchronous wake level
    logic T_RSTn;     // stretched core reset, active-low
    logic T_Sel_PLL;  // 1 = PLL, 0 = oscillator
    logic XTALoffn;   // 0 gates the core clock off
    logic PLL_EN;     // PLL power enable
    logic CLK_BUSY;   // sequencer in a transitional state
    logic LOCK_FAIL;  // sticky lock timeout / lock-loss flag

    modport slave (
        input  PLL_LOCK, PLL_REQ, SLEEP_REQ, WAKE,
        output T_RSTn, T_Sel_PLL, XTALoffn, PLL_EN, CLK_BUSY, LOCK_FAIL
    );

    modport master (
        output PLL_LOCK, PLL_REQ, SLEEP_REQ, WAKE,
        input  T_RSTn, T_Sel_PLL, XTALoffn, PLL_EN, CLK_BUSY, LOCK_FAIL
    );
endinterface

// File: rtl/glogic_clk_seq.sv
// Clock/reset sequencer ahead of the chip glue logic.
// Stretches the core reset, chooses between oscillator and PLL, and brackets
// every source change with clock gating (XTALoffn=0) so the downstream
// NAND-formed core clock never glitches. Also handles PLL lock timeout,
// lock-loss fallback, sleep and wake. All outputs come straight from flops.
module glogic_clk_seq #(
    parameter int RST_CYC    = 16,
    parameter int LOCK_TO    = 4096,
    parameter int SETTLE_CYC = 64,
    parameter int GAP_CYC    = 4,
    parameter int CNT_W      = 13
) (
    input  logic                 T_CLKI_OSC,
    input  logic                 T_RST,
    glogic_clk_seq_if.slave      bus
);

    typedef enum logic [3:0] {
        ST_RST_HOLD   = 4'd0,
        ST_OSC_RUN    = 4'd1,
        ST_LOCK_WAIT  = 4'd2,
        ST_SETTLE     = 4'd3,
        ST_SW_PLL     = 4'd4,
        ST_PLL_RUN    = 4'd5,
        ST_SW_OSC     = 4'd6,
        ST_GATE_SLEEP = 4'd7,
        ST_SLEEP      = 4'd8
    } state_t;

    // Counter values sampled on the edge that completes each interval.
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP2_LAST   = CNT_W'(2 * GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [1:0]       wake_sync_q, wake_sync_d;
    logic             t_rstn_q, t_rstn_d;
    logic             sel_pll_q, sel_pll_d;
    logic             xtal_on_q, xtal_on_d;
    logic             pll_en_q, pll_en_d;
    logic             busy_q, busy_d;
    logic             lock_fail_q, lock_fail_d;
    logic             sleep_pend_q, sleep_pend_d;

    logic lock_s;
    logic wake_s;
    logic pll_req;
    logic sleep_req;

    assign lock_s    = lock_sync_q[1];
    assign wake_s    = wake_sync_q[1];
    assign pll_req   = bus.PLL_REQ;
    assign sleep_req = bus.SLEEP_REQ;

    assign bus.T_RSTn    = t_rstn_q;
    assign bus.T_Sel_PLL = sel_pll_q;
    assign bus.XTALoffn  = xtal_on_q;
    assign bus.PLL_EN    = pll_en_q;
    assign bus.CLK_BUSY  = busy_q;
    assign bus.LOCK_FAIL = lock_fail_q;

    // Next-state, counter and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        lock_sync_d  = {lock_sync_q[0], bus.PLL_LOCK};
        wake_sync_d  = {wake_sync_q[0], bus.WAKE};
        t_rstn_d     = t_rstn_q;
        sel_pll_d    = sel_pll_q;
        xtal_on_d    = xtal_on_q;
        pll_en_d     = pll_en_q;
        busy_d       = busy_q;
        sleep_pend_d = sleep_pend_q;

        // A withdrawn PLL request acknowledges a previous failure; a new
        // failure raised below in the same cycle still wins.
        if (!pll_req) begin
            lock_fail_d = 1'b0;
        end else begin
            lock_fail_d = lock_fail_q;
        end

        case (state_q)
            ST_RST_HOLD: begin
                xtal_on_d = 1'b1;
                if (cnt_q == RST_LAST) begin
                    t_rstn_d = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = CNT_ZERO;
                    state_d  = ST_OSC_RUN;
                end else begin
                    t_rstn_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            ST_OSC_RUN: begin
                cnt_d = CNT_ZERO;
                if (sleep_req) begin
                    xtal_on_d = 1'b0;
                    pll_en_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_GATE_SLEEP;
                end else if (pll_req && !lock_fail_q) begin
                    pll_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_LOCK_WAIT;
                end else begin
                    xtal_on_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end

            ST_LOCK_WAIT: begin
                if (!pll_req) begin
                    pll_en_d = 1'b0;
                    busy_d   = 1'b0;
                    cnt_d    = CNT_ZERO;
                    state_d  = ST_OSC_RUN;
                end else if (lock_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    lock_fail_d = 1'b1;
                    pll_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = CNT_ZERO;
                    state_d     = ST_OSC_RUN;
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (!pll_req) begin
                    pll_en_d = 1'b0;
                    busy_d   = 1'b0;
                    cnt_d    = CNT_ZERO;
                    state_d  = ST_OSC_RUN;
                end else if (!lock_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_LOCK_WAIT;
                end else if (cnt_q == SETTLE_LAST) begin
                    xtal_on_d = 1'b0;
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_SW_PLL;
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_SW_PLL: begin
                // Not interruptible; a sleep pulse is remembered for PLL_RUN.
                if (sleep_req) begin
                    sleep_pend_d = 1'b1;
                end else begin
                    sleep_pend_d = sleep_pend_q;
                end
                if (cnt_q == GAP_LAST) begin
                    sel_pll_d = 1'b1;
                end else if (cnt_q == GAP2_LAST) begin
                    xtal_on_d = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_PLL_RUN;
                end else begin
                    xtal_on_d = 1'b0;
                end
            end

            ST_PLL_RUN: begin
                cnt_d = CNT_ZERO;
                if (!lock_s) begin
                    // Lock loss: gate immediately, remember any sleep request.
                    xtal_on_d    = 1'b0;
                    lock_fail_d  = 1'b1;
                    busy_d       = 1'b1;
                    sleep_pend_d = sleep_req | sleep_pend_q;
                    state_d      = ST_SW_OSC;
                end else if (sleep_req || sleep_pend_q || !pll_req) begin
                    xtal_on_d    = 1'b0;
                    busy_d       = 1'b1;
                    sleep_pend_d = sleep_req | sleep_pend_q;
                    state_d      = ST_SW_OSC;
                end else begin
                    xtal_on_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end

            ST_SW_OSC: begin
                if (sleep_req) begin
                    sleep_pend_d = 1'b1;
                end else begin
                    sleep_pend_d = sleep_pend_q;
                end
                if (cnt_q == GAP_LAST) begin
                    sel_pll_d = 1'b0;
                    pll_en_d  = 1'b0;
                end else if (cnt_q == GAP2_LAST) begin
                    busy_d = 1'b0;
                    cnt_d  = CNT_ZERO;
                    if (sleep_pend_q || sleep_req) begin
                        // Stay gated and drop straight into sleep.
                        sleep_pend_d = 1'b0;
                        xtal_on_d    = 1'b0;
                        state_d      = ST_SLEEP;
                    end else begin
                        xtal_on_d = 1'b1;
                        state_d   = ST_OSC_RUN;
                    end
                end else begin
                    xtal_on_d = 1'b0;
                end
            end

            ST_GATE_SLEEP: begin
                xtal_on_d = 1'b0;
                pll_en_d  = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = CNT_ZERO;
                state_d   = ST_SLEEP;
            end

            ST_SLEEP: begin
                busy_d = 1'b0;
                if (!wake_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == GAP_LAST) begin
                    xtal_on_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_OSC_RUN;
                end else begin
                    xtal_on_d = 1'b0;
                end
            end

            default: begin
                // Corrupted state: fall back to a gated oscillator selection;
                // OSC_RUN re-enables the clock on the following cycle.
                sel_pll_d    = 1'b0;
                pll_en_d     = 1'b0;
                xtal_on_d    = 1'b0;
                busy_d       = 1'b0;
                sleep_pend_d = 1'b0;
                cnt_d        = CNT_ZERO;
                state_d      = ST_OSC_RUN;
            end
        endcase
    end

    // State, counter, synchronizer and output registers with async reset.
    always_ff @(posedge T_CLKI_OSC or posedge T_RST) begin
        if (T_RST) begin
            state_q      <= ST_RST_HOLD;
            cnt_q        <= CNT_ZERO;
            lock_sync_q  <= 2'b00;
            wake_sync_q  <= 2'b00;
            t_rstn_q     <= 1'b0;
            sel_pll_q    <= 1'b0;
            xtal_on_q    <= 1'b0;
            pll_en_q     <= 1'b0;
            busy_q       <= 1'b1;
            lock_fail_q  <= 1'b0;
            sleep_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_sync_q  <= lock_sync_d;
            wake_sync_q  <= wake_sync_d;
            t_rstn_q     <= t_rstn_d;
            sel_pll_q    <= sel_pll_d;
            xtal_on_q    <= xtal_on_d;
            pll_en_q     <= pll_en_d;
            busy_q       <= busy_d;
            lock_fail_q  <= lock_fail_d;
            sleep_pend_q <= sleep_pend_d;
        end
    end

endmodule

// File: tb/tb_glogic_clk_seq.sv
// Directed testbench for glogic_clk_seq: reset stretch, PLL switch-in,
// lock loss, lock timeout, sleep/wake and asynchronous reset mid-switch.
`timescale 1ns/1ps
module tb_glogic_clk_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   sel_viol;
    int   gated_cnt;
    logic prev_sel;

    glogic_clk_seq_if bus_if();

    glogic_clk_seq dut (
        .T_CLKI_OSC (clk),
        .T_RST      (rst),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Select may only change after the clock has been gated for GAP cycles.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            gated_cnt = 0;
        end else begin
            if (bus_if.T_Sel_PLL !== prev_sel &&
                (bus_if.XTALoffn !== 1'b0 || gated_cnt < 4)) begin
                sel_viol = sel_viol + 1;
            end
            if (bus_if.XTALoffn === 1'b0) gated_cnt = gated_cnt + 1;
            else gated_cnt = 0;
        end
        prev_sel = bus_if.T_Sel_PLL;
    end

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1;
        bus_if.PLL_LOCK = 1'b0; bus_if.PLL_REQ = 1'b0;
        bus_if.SLEEP_REQ = 1'b0; bus_if.WAKE = 1'b0;
        tick(2);
        got = {bus_if.T_RSTn, bus_if.T_Sel_PLL, bus_if.XTALoffn,
               bus_if.PLL_EN, bus_if.CLK_BUSY, bus_if.LOCK_FAIL};
        n_tests++; if (got !== 6'b000010) begin n_fail++; $display("FAIL reset_values: got %b expected %b", got, 6'b000010); end
        rst = 1'b0;
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b1) begin n_fail++; $display("FAIL rst_xtal_edge1: got %b expected 1", bus_if.XTALoffn); end
        n_tests++; if (bus_if.T_RSTn !== 1'b0) begin n_fail++; $display("FAIL rst_rstn_edge1: got %b expected 0", bus_if.T_RSTn); end
        tick(14);
        n_tests++; if (bus_if.T_RSTn !== 1'b0) begin n_fail++; $display("FAIL rst_rstn_edge15: got %b expected 0", bus_if.T_RSTn); end
        n_tests++; if (bus_if.CLK_BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_busy_edge15: got %b expected 1", bus_if.CLK_BUSY); end
        tick(1);
        n_tests++; if (bus_if.T_RSTn !== 1'b1) begin n_fail++; $display("FAIL rst_rstn_edge16: got %b expected 1", bus_if.T_RSTn); end
        n_tests++; if (bus_if.CLK_BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy_edge16: got %b expected 0", bus_if.CLK_BUSY); end
    endtask

    task automatic test_pll_switch();
        bus_if.PLL_REQ = 1'b1;
        tick(1);
        n_tests++; if (bus_if.PLL_EN !== 1'b1 || bus_if.CLK_BUSY !== 1'b1) begin n_fail++; $display("FAIL sw_pll_en: got en=%b busy=%b expected en=1 busy=1", bus_if.PLL_EN, bus_if.CLK_BUSY); end
        tick(99);
        bus_if.PLL_LOCK = 1'b1;
        tick(66);   // two sync edges + SETTLE entry + 63 settle edges
        n_tests++; if (bus_if.XTALoffn !== 1'b1) begin n_fail++; $display("FAIL sw_settle_not_done: got xtal=%b expected 1", bus_if.XTALoffn); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b0 || bus_if.T_Sel_PLL !== 1'b0) begin n_fail++; $display("FAIL sw_gate: got xtal=%b sel=%b expected 0 0", bus_if.XTALoffn, bus_if.T_Sel_PLL); end
        tick(3);
        n_tests++; if (bus_if.T_Sel_PLL !== 1'b0) begin n_fail++; $display("FAIL sw_sel_early: got %b expected 0", bus_if.T_Sel_PLL); end
        tick(1);
        n_tests++; if (bus_if.T_Sel_PLL !== 1'b1 || bus_if.XTALoffn !== 1'b0) begin n_fail++; $display("FAIL sw_sel_set: got sel=%b xtal=%b expected 1 0", bus_if.T_Sel_PLL, bus_if.XTALoffn); end
        tick(3);
        n_tests++; if (bus_if.XTALoffn !== 1'b0) begin n_fail++; $display("FAIL sw_xtal_early: got %b expected 0", bus_if.XTALoffn); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.CLK_BUSY !== 1'b0 || bus_if.PLL_EN !== 1'b1) begin n_fail++; $display("FAIL sw_pll_run: got xtal=%b busy=%b en=%b expected 1 0 1", bus_if.XTALoffn, bus_if.CLK_BUSY, bus_if.PLL_EN); end
    endtask

    task automatic test_lock_loss();
        bus_if.PLL_LOCK = 1'b0;
        tick(2);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.LOCK_FAIL !== 1'b0) begin n_fail++; $display("FAIL loss_sync: got xtal=%b fail=%b expected 1 0", bus_if.XTALoffn, bus_if.LOCK_FAIL); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b0 || bus_if.LOCK_FAIL !== 1'b1 || bus_if.CLK_BUSY !== 1'b1) begin n_fail++; $display("FAIL loss_gate: got xtal=%b fail=%b busy=%b expected 0 1 1", bus_if.XTALoffn, bus_if.LOCK_FAIL, bus_if.CLK_BUSY); end
        tick(3);
        n_tests++; if (bus_if.T_Sel_PLL !== 1'b1 || bus_if.PLL_EN !== 1'b1) begin n_fail++; $display("FAIL loss_sel_hold: got sel=%b en=%b expected 1 1", bus_if.T_Sel_PLL, bus_if.PLL_EN); end
        tick(1);
        n_tests++; if (bus_if.T_Sel_PLL !== 1'b0 || bus_if.PLL_EN !== 1'b0) begin n_fail++; $display("FAIL loss_sel_osc: got sel=%b en=%b expected 0 0", bus_if.T_Sel_PLL, bus_if.PLL_EN); end
        tick(3);
        n_tests++; if (bus_if.XTALoffn !== 1'b0) begin n_fail++; $display("FAIL loss_gap2: got xtal=%b expected 0", bus_if.XTALoffn); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.CLK_BUSY !== 1'b0) begin n_fail++; $display("FAIL loss_osc_run: got xtal=%b busy=%b expected 1 0", bus_if.XTALoffn, bus_if.CLK_BUSY); end
        tick(3);
        n_tests++; if (bus_if.PLL_EN !== 1'b0 || bus_if.LOCK_FAIL !== 1'b1) begin n_fail++; $display("FAIL loss_req_ignored: got en=%b fail=%b expected 0 1", bus_if.PLL_EN, bus_if.LOCK_FAIL); end
        bus_if.PLL_REQ = 1'b0;
        tick(1);
        n_tests++; if (bus_if.LOCK_FAIL !== 1'b0) begin n_fail++; $display("FAIL loss_fail_clear: got %b expected 0", bus_if.LOCK_FAIL); end
    endtask

    task automatic test_lock_timeout();
        bus_if.PLL_REQ = 1'b1;
        tick(1);
        n_tests++; if (bus_if.PLL_EN !== 1'b1) begin n_fail++; $display("FAIL to_en: got %b expected 1", bus_if.PLL_EN); end
        tick(4095);
        n_tests++; if (bus_if.LOCK_FAIL !== 1'b0 || bus_if.PLL_EN !== 1'b1) begin n_fail++; $display("FAIL to_4095: got fail=%b en=%b expected 0 1", bus_if.LOCK_FAIL, bus_if.PLL_EN); end
        tick(1);
        n_tests++; if (bus_if.LOCK_FAIL !== 1'b1 || bus_if.PLL_EN !== 1'b0 || bus_if.CLK_BUSY !== 1'b0) begin n_fail++; $display("FAIL to_4096: got fail=%b en=%b busy=%b expected 1 0 0", bus_if.LOCK_FAIL, bus_if.PLL_EN, bus_if.CLK_BUSY); end
        tick(3);
        n_tests++; if (bus_if.PLL_EN !== 1'b0) begin n_fail++; $display("FAIL to_req_ignored: got %b expected 0", bus_if.PLL_EN); end
        bus_if.PLL_REQ = 1'b0;
        tick(1);
        n_tests++; if (bus_if.LOCK_FAIL !== 1'b0) begin n_fail++; $display("FAIL to_fail_clear: got %b expected 0", bus_if.LOCK_FAIL); end
    endtask

    task automatic test_sleep_wake();
        int waited;
        bus_if.PLL_LOCK = 1'b1;
        bus_if.PLL_REQ  = 1'b1;
        waited = 0;
        while (!(bus_if.T_Sel_PLL === 1'b1 && bus_if.XTALoffn === 1'b1 && bus_if.CLK_BUSY === 1'b0) && waited < 200) begin
            tick(1);
            waited++;
        end
        n_tests++; if (waited >= 200) begin n_fail++; $display("FAIL sl_reach_pll_run: timed out after %0d cycles, expected < 200", waited); end
        bus_if.SLEEP_REQ = 1'b1;
        tick(1);
        bus_if.SLEEP_REQ = 1'b0;
        bus_if.PLL_REQ   = 1'b0;
        n_tests++; if (bus_if.XTALoffn !== 1'b0 || bus_if.CLK_BUSY !== 1'b1) begin n_fail++; $display("FAIL sl_gate: got xtal=%b busy=%b expected 0 1", bus_if.XTALoffn, bus_if.CLK_BUSY); end
        tick(4);
        n_tests++; if (bus_if.T_Sel_PLL !== 1'b0 || bus_if.PLL_EN !== 1'b0) begin n_fail++; $display("FAIL sl_sel_osc: got sel=%b en=%b expected 0 0", bus_if.T_Sel_PLL, bus_if.PLL_EN); end
        tick(4);
        n_tests++; if (bus_if.XTALoffn !== 1'b0 || bus_if.CLK_BUSY !== 1'b0 || bus_if.T_RSTn !== 1'b1) begin n_fail++; $display("FAIL sl_sleep: got xtal=%b busy=%b rstn=%b expected 0 0 1", bus_if.XTALoffn, bus_if.CLK_BUSY, bus_if.T_RSTn); end
        tick(5);
        n_tests++; if (bus_if.XTALoffn !== 1'b0) begin n_fail++; $display("FAIL sl_stays: got xtal=%b expected 0", bus_if.XTALoffn); end
        bus_if.WAKE = 1'b1;
        tick(5);
        n_tests++; if (bus_if.XTALoffn !== 1'b0) begin n_fail++; $display("FAIL wk_early: got xtal=%b expected 0", bus_if.XTALoffn); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.CLK_BUSY !== 1'b0) begin n_fail++; $display("FAIL wk_on: got xtal=%b busy=%b expected 1 0", bus_if.XTALoffn, bus_if.CLK_BUSY); end
        bus_if.WAKE = 1'b0;
        tick(2);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.PLL_EN !== 1'b0 || bus_if.CLK_BUSY !== 1'b0) begin n_fail++; $display("FAIL wk_osc_run: got xtal=%b en=%b busy=%b expected 1 0 0", bus_if.XTALoffn, bus_if.PLL_EN, bus_if.CLK_BUSY); end
    endtask

    task automatic test_reset_mid_switch();
        int waited;
        logic [5:0] got;
        bus_if.PLL_REQ = 1'b1;
        waited = 0;
        while (bus_if.T_Sel_PLL !== 1'b1 && waited < 200) begin
            tick(1);
            waited++;
        end
        n_tests++; if (waited >= 200) begin n_fail++; $display("FAIL ar_reach_phase2: timed out after %0d cycles, expected < 200", waited); end
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b0 || bus_if.T_Sel_PLL !== 1'b1) begin n_fail++; $display("FAIL ar_phase2: got xtal=%b sel=%b expected 0 1", bus_if.XTALoffn, bus_if.T_Sel_PLL); end
        #2;
        rst = 1'b1;
        #1;
        got = {bus_if.T_RSTn, bus_if.T_Sel_PLL, bus_if.XTALoffn,
               bus_if.PLL_EN, bus_if.CLK_BUSY, bus_if.LOCK_FAIL};
        n_tests++; if (got !== 6'b000010) begin n_fail++; $display("FAIL ar_async_values: got %b expected %b", got, 6'b000010); end
        bus_if.PLL_REQ  = 1'b0;
        bus_if.PLL_LOCK = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_tests++; if (bus_if.XTALoffn !== 1'b1 || bus_if.T_RSTn !== 1'b0) begin n_fail++; $display("FAIL ar_edge1: got xtal=%b rstn=%b expected 1 0", bus_if.XTALoffn, bus_if.T_RSTn); end
        tick(14);
        n_tests++; if (bus_if.T_RSTn !== 1'b0) begin n_fail++; $display("FAIL ar_edge15: got rstn=%b expected 0", bus_if.T_RSTn); end
        tick(1);
        n_tests++; if (bus_if.T_RSTn !== 1'b1 || bus_if.CLK_BUSY !== 1'b0 || bus_if.T_Sel_PLL !== 1'b0) begin n_fail++; $display("FAIL ar_edge16: got rstn=%b busy=%b sel=%b expected 1 0 0", bus_if.T_RSTn, bus_if.CLK_BUSY, bus_if.T_Sel_PLL); end
    endtask

    task automatic test_sel_gating();
        n_tests++; if (sel_viol !== 0) begin n_fail++; $display("FAIL sel_gating: got %0d select changes with clock not gated, expected 0", sel_viol); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        sel_viol  = 0;
        gated_cnt = 0;
        prev_sel  = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_pll_switch();
        test_lock_loss();
        test_lock_timeout();
        test_sleep_wake();
        test_reset_mid_switch();
        test_sel_gating();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound in case a test stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
